spi_master_ctrl: RTL

SPI initiator that issues single register read/write transactions to the design's sampled SPI register slave: mode CPOL=0/CPHA=1, MSB first, 16-bit frame of command byte plus data byte. It sits between an on-chip requester (test logic or a host-side bridge) and the `sclk`/`mosi`/`miso`/`cs` pins. It generates `sclk` by dividing `clk`, shifts out the frame, captures read data, and reports completion with a one-cycle pulse.

---
 rtl/spi_pkg.sv | 43 ++++
 rtl/spi_phase_timer.sv | 38 +++
 rtl/spi_master_ctrl.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared constants, state encoding and frame builder for the
//               SPI register-access initiator.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Frame geometry: one command byte followed by one data byte
    localparam int SPI_FRAME_BITS   = 16;
    localparam int SPI_ADDR_W       = 4;
    localparam int SPI_DATA_W       = 8;
    localparam int SPI_CMD_READ_BIT = 7;
    localparam int SPI_BITCNT_W     = 5;
    localparam int SPI_TIMER_W      = 8;

    // Controller states
    localparam int SPI_STATE_W = 3;
    localparam logic [SPI_STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [SPI_STATE_W-1:0] ST_SETUP = 3'd1;
    localparam logic [SPI_STATE_W-1:0] ST_HIGH  = 3'd2;
    localparam logic [SPI_STATE_W-1:0] ST_LOW   = 3'd3;
    localparam logic [SPI_STATE_W-1:0] ST_HOLD  = 3'd4;
    localparam logic [SPI_STATE_W-1:0] ST_GAP   = 3'd5;

    // Assemble the outgoing frame: {rw, 3'b000, addr, data}; reads send 0x00
    function automatic logic [SPI_FRAME_BITS-1:0] spi_build_frame(
        input logic                  rw,
        input logic [SPI_ADDR_W-1:0] addr,
        input logic [SPI_DATA_W-1:0] wdata
    );
        logic [SPI_DATA_W-1:0] cmd;
        logic [SPI_DATA_W-1:0] dat;
        cmd = '0;
        cmd[SPI_CMD_READ_BIT]   = rw;
        cmd[SPI_ADDR_W-1:0]     = addr;
        dat = rw ? '0 : wdata;
        return {cmd, dat};
    endfunction

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : spi_phase_timer
// Description : Loadable down-counter pacing every timed controller phase.
//               A load reloads CLK_DIV-1; the count then runs down to 0 and
//               holds there, with tc flagging the final cycle of the phase.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_phase_timer
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic tc
);

    localparam logic [SPI_TIMER_W-1:0] C_RELOAD = SPI_TIMER_W'(CLK_DIV - 1);

    logic [SPI_TIMER_W-1:0] r_count;

    // Reload on every state change, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= C_RELOAD;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign tc = (r_count == '0);

endmodule : spi_phase_timer
`default_nettype wire

// File: rtl/spi_master_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : spi_master_ctrl
// Description : SPI initiator (CPOL=0/CPHA=1, MSB first, 16-bit frame) for
//               single register reads and writes. sclk is clk divided by
//               2*CLK_DIV; completion is signalled by a one-cycle done pulse.
//               Build option SPI_MASTER_MISO_SYNC_EN inserts a 2-flop
//               synchronizer on miso (CLK_DIV must then be at least 6).
// Revision    : 1.0 - initial release
// ============================================================================
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [SPI_ADDR_W-1:0] addr,
    input  logic [SPI_DATA_W-1:0] wdata,
    output logic                  busy,
    output logic                  done,
    output logic [SPI_DATA_W-1:0] rdata,
    output logic                  sclk,
    output logic                  mosi,
    input  logic                  miso,
    output logic                  cs
);

    logic [SPI_STATE_W-1:0]    r_state;
    logic [SPI_STATE_W-1:0]    w_next;
    logic                      w_load;
    logic                      w_tc;
    logic [SPI_BITCNT_W-1:0]   r_bit_cnt;
    logic [SPI_FRAME_BITS-1:0] r_tx;
    logic [SPI_DATA_W-1:0]     r_rx;
    logic                      r_is_read;
    logic                      r_sclk;
    logic                      r_mosi;
    logic                      r_cs;
    logic                      r_done;
    logic [SPI_DATA_W-1:0]     r_rdata;
    logic                      w_miso_s;
    logic                      w_accept;
    logic                      w_enter_high;
    logic                      w_sample;
    logic                      w_enter_gap;
    logic                      w_bits_left;

`ifdef SPI_MASTER_MISO_SYNC_EN
    logic r_miso_meta;
    logic r_miso_sync;

    // Two-flop synchronizer; sample point is unchanged so the margin shrinks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_miso_meta <= 1'b0;
            r_miso_sync <= 1'b0;
        end else begin
            r_miso_meta <= miso;
            r_miso_sync <= r_miso_meta;
        end
    end

    assign w_miso_s = r_miso_sync;
`else
    assign w_miso_s = miso;
`endif

    spi_phase_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_load),
        .tc    (w_tc)
    );

    assign w_bits_left = (r_bit_cnt < SPI_BITCNT_W'(SPI_FRAME_BITS));

    // Next-state selection; every timed phase ends on the timer terminal count
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_next = ST_SETUP;
            ST_SETUP: if (w_tc)  w_next = ST_HIGH;
            ST_HIGH:  if (w_tc)  w_next = ST_LOW;
            ST_LOW:   if (w_tc)  w_next = w_bits_left ? ST_HIGH : ST_HOLD;
            ST_HOLD:  if (w_tc)  w_next = ST_GAP;
            ST_GAP:   if (w_tc)  w_next = ST_IDLE;
            default:             w_next = ST_IDLE;
        endcase
    end

    // Every state change restarts the phase timer
    assign w_load       = (w_next != r_state);
    assign w_accept     = (r_state == ST_IDLE) && start;
    assign w_enter_high = w_load && (w_next == ST_HIGH);
    assign w_sample     = (r_state == ST_HIGH) && w_tc;
    assign w_enter_gap  = (r_state == ST_HOLD) && w_tc;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Transmit shift register and bit counter; a bit leaves on each sclk rise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx      <= '0;
            r_bit_cnt <= '0;
            r_is_read <= 1'b0;
        end else if (w_accept) begin
            r_tx      <= spi_build_frame(rw, addr, wdata);
            r_bit_cnt <= '0;
            r_is_read <= rw;
        end else if (w_enter_high) begin
            r_tx      <= {r_tx[SPI_FRAME_BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 1'b1;
        end
    end

    // Receive shift register; after 16 samples it holds the last 8 (data byte)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx <= '0;
        end else if (w_sample) begin
            r_rx <= {r_rx[SPI_DATA_W-2:0], w_miso_s};
        end
    end

    // Registered pins: sclk follows HIGH, mosi moves only on sclk rise, cs frames the transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk <= 1'b0;
            r_mosi <= 1'b0;
            r_cs   <= 1'b1;
        end else begin
            if (w_accept) begin
                r_cs <= 1'b0;
            end else if (w_enter_gap) begin
                r_cs <= 1'b1;
            end
            if (w_enter_high) begin
                r_sclk <= 1'b1;
                r_mosi <= r_tx[SPI_FRAME_BITS-1];
            end else if (w_sample) begin
                r_sclk <= 1'b0;
            end
        end
    end

    // Completion pulse and read-result capture in the first GAP cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done  <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_done <= w_enter_gap;
            if (w_enter_gap && r_is_read) begin
                r_rdata <= r_rx;
            end
        end
    end

    assign busy  = (r_state != ST_IDLE);
    assign done  = r_done;
    assign rdata = r_rdata;
    assign sclk  = r_sclk;
    assign mosi  = r_mosi;
    assign cs    = r_cs;

endmodule : spi_master_ctrl
`default_nettype wire
